bubsys_cen_gen: RTL and testbench
=================================

Name: bubsys_cen_gen

Overview:
Parametrised clock-enable generator for the BubSys emulation core. It derives NCH independent pairs of active-low positive/negative-phase clock enables (the CLKxMPCEN_n/CLKxMNCEN_n flat-cable set) from the single emulation master clock. Each channel runs in integer-divider or fractional-accumulator mode and can be reprogrammed at runtime. All channels support a global halt and a phase resync, so CPU, video and screen-sim blocks can be stepped and realigned together.

Parameters:
NCH, 3, number of enable channels (1..8)
CNT_W, 5, integer-divider counter width
ACC_W, 16, fractional accumulator width
DEF_DIV, {5'd6,5'd4,5'd2}, per-channel reset divider, channel 0 in the LSBs (18/9/6 MHz from a 36 MHz MCLK)

Ports:
i_EMU_MCLK  in  1  master clock; the only clock
i_EMU_MRST  in  1  synchronous active-high reset
i_HALT  in  1  freeze all channels while high
i_RESYNC  in  1  single-cycle strobe that realigns every channel to phase 0
i_CFG_WR  in  1  configuration write strobe
i_CFG_CH  in  3  target channel index
i_CFG_DATA  in  ACC_W+1  bit ACC_W is the mode (0 = integer, 1 = fractional); low bits hold the divider or the increment
o_PCEN_n  out  NCH  positive-phase enable, active-low, one MCLK wide
o_NCEN_n  out  NCH  negative-phase enable, active-low, one MCLK wide

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset has top priority.
- Reset values: all outputs 1; counters and accumulators 0; mode integer; divider = DEF_DIV slice; pending-config flags 0.
- Outputs are registered. o_PCEN_n[c] in cycle k+1 = ~(phase event of cycle k).
- Integer mode, divider D:
  - cnt counts 0..D-1, then wraps to 0.
  - PCEN event when cnt==0.
  - NCEN event when cnt==floor(D/2).
  - D<2 is clamped to 2.
- Fractional mode, increment I:
  - acc <= acc+I each cycle (ACC_W-bit, wraps).
  - PCEN event on carry-out.
  - NCEN event when the acc MSB goes 0->1.
  - I==0 means the channel is idle: no events.
- Halt: while i_HALT=1, counters and accumulators hold and both outputs are forced to 1. On release, counting resumes from the held value with no extra or skipped events.
- Resync:
  - i_RESYNC=1 loads every cnt and acc with 0 and forces outputs to 1 in the following cycle.
  - Any pending config is applied at the same time.
  - Resync beats halt. The channels then behave as if just out of reset.
- Config write:
  - i_CFG_WR captures mode and value into the channel's pending register and sets its pending flag.
  - A later write before application overwrites the pending value.
  - Pending config is applied on the cycle the channel generates a PCEN event: integer wrap to 0, or fractional carry. The new mode and value govern the next cycle onward, so no runt or double pulse occurs.
  - An idle fractional channel (I==0) applies pending config immediately.
  - i_CFG_CH>=NCH: the write is ignored.
- Simultaneous events:
  - i_CFG_WR with i_RESYNC: the write is captured first, then applied by the resync.
  - i_CFG_WR during halt: captured and applied at the first post-halt PCEN event.
- Reset mid-operation discards pending config; DEF_DIV is restored.
- Channels are fully independent apart from the shared halt and resync.

Decomposition:
- Package bubsys_cen_pkg holds:
  - NCH_MAX
  - CNT_W and ACC_W defaults
  - mode enum (CEN_INT, CEN_FRAC)
  - config record typedef {mode, value}
  - default divider constants for 18/9/6 MHz
- Sub-module bubsys_cen_chan implements one channel: counter, accumulator, pending register and output flops. The top level holds the generate loop, config decode and the shared halt/resync fan-out.

Test Plan:
- Reset release with defaults:
  - ch1 (D=4): PCEN_n low in cycles 1,5,9; NCEN_n low in cycles 3,7,11.
  - ch0 (D=2): PCEN_n low on odd cycles, NCEN_n low on even cycles from cycle 2.
  - ch2 (D=6): PCEN_n low in cycles 1,7,13; NCEN_n low in cycles 4,10.
- Halt: ch1 with i_HALT held for 3 cycles starting at cycle 4 -> no enables during the halt; on release, PCEN_n low exactly 4 active cycles after the prior one (cycle 8).
- Config write ch1 = integer 8 at cycle 2 -> the old D=4 period completes (PCEN_n low at cycle 5), then PCEN_n low at 13,21 and NCEN_n low at 9,17.
- Fractional: ch2 = {1,16'h4000} -> after the next ch2 PCEN event, PCEN_n low every 4 cycles and NCEN_n low 2 cycles after each PCEN_n. Increment 0 -> both outputs stay 1.
- Resync at an arbitrary cycle -> all outputs 1 the next cycle, then all PCEN_n go low together one cycle later. A pending ch0 = 4 is applied at the resync.
- Reset asserted mid-run with ch1 pending -> outputs 1; the pending config is lost and the DEF_DIV timing of scenario 1 repeats.

Source files
------------

// File: rtl/bubsys_cen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bubsys_cen_pkg : shared types and constants for the clock-enable gen |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bubsys_cen_pkg;

  localparam int NCH_MAX     = 8;
  localparam int CEN_NCH_DEF = 3;
  localparam int CEN_CNT_W   = 5;
  localparam int CEN_ACC_W   = 16;
  localparam int CEN_CH_W    = $clog2(NCH_MAX);

  // Dividers for 18/9/6 MHz enables from a 36 MHz master clock
  localparam logic [CEN_CNT_W-1:0] CEN_DIV_18M = CEN_CNT_W'(2);
  localparam logic [CEN_CNT_W-1:0] CEN_DIV_9M  = CEN_CNT_W'(4);
  localparam logic [CEN_CNT_W-1:0] CEN_DIV_6M  = CEN_CNT_W'(6);

  typedef enum logic {
    CEN_INT  = 1'b0,
    CEN_FRAC = 1'b1
  } cen_mode_e;

  typedef struct packed {
    cen_mode_e              mode;
    logic [CEN_ACC_W-1:0]   value;
  } cen_cfg_t;

  // Integer dividers keep only the counter-width bits and never go below 2
  function automatic cen_cfg_t cen_norm(input cen_cfg_t cfg);
    cen_cfg_t r;
    r = cfg;
    if (cfg.mode == CEN_INT) begin
      r.value = '0;
      r.value[CEN_CNT_W-1:0] = (cfg.value[CEN_CNT_W-1:0] < CEN_CNT_W'(2)) ?
                               CEN_CNT_W'(2) : cfg.value[CEN_CNT_W-1:0];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bubsys_cen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bubsys_cen_if : control and enable-output bundle of bubsys_cen_gen   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface bubsys_cen_if
  import bubsys_cen_pkg::*;
#(
  parameter int NCH   = CEN_NCH_DEF,
  parameter int ACC_W = CEN_ACC_W
);

  logic                i_HALT;
  logic                i_RESYNC;
  logic                i_CFG_WR;
  logic [CEN_CH_W-1:0] i_CFG_CH;
  logic [ACC_W:0]      i_CFG_DATA;
  logic [NCH-1:0]      o_PCEN_n;
  logic [NCH-1:0]      o_NCEN_n;

  modport master (
    output i_HALT, i_RESYNC, i_CFG_WR, i_CFG_CH, i_CFG_DATA,
    input  o_PCEN_n, o_NCEN_n
  );

  modport slave (
    input  i_HALT, i_RESYNC, i_CFG_WR, i_CFG_CH, i_CFG_DATA,
    output o_PCEN_n, o_NCEN_n
  );

endinterface
`default_nettype wire

// File: rtl/bubsys_cen_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bubsys_cen_chan : one P/N enable channel, integer or fractional      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bubsys_cen_chan
  import bubsys_cen_pkg::*;
#(
  parameter int                CNT_W   = CEN_CNT_W,
  parameter int                ACC_W   = CEN_ACC_W,
  parameter logic [CNT_W-1:0]  DEF_DIV = CEN_DIV_18M
) (
  input  wire logic     clk,
  input  wire logic     rst,
  input  wire logic     i_halt,
  input  wire logic     i_resync,
  input  wire logic     i_wr_en,
  input  wire cen_cfg_t i_wr_cfg,
  output logic          o_pcen_n,
  output logic          o_ncen_n
);

  localparam cen_cfg_t c_def_cfg =
    cen_norm(cen_cfg_t'{mode: CEN_INT, value: CEN_ACC_W'(DEF_DIV)});

  cen_cfg_t         cur_q, cur_d;
  cen_cfg_t         pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             pcen_n_q, pcen_n_d;
  logic             ncen_n_q, ncen_n_d;

  cen_cfg_t         w_pend_eff;
  logic             w_pend_vld_eff;
  logic             w_int;
  logic             w_idle;
  logic [CNT_W-1:0] w_div;
  logic [ACC_W:0]   w_sum;
  logic             w_ev_p;
  logic             w_ev_n;

  // A write arriving this cycle is already visible to any apply point
  always_comb begin
    w_pend_eff     = i_wr_en ? i_wr_cfg : pend_q;
    w_pend_vld_eff = i_wr_en | pend_vld_q;
    w_int          = (cur_q.mode == CEN_INT);
    w_div          = cur_q.value[CNT_W-1:0];
    w_sum          = {1'b0, acc_q} + {1'b0, cur_q.value[ACC_W-1:0]};
    w_idle         = !w_int && (cur_q.value[ACC_W-1:0] == '0);
    w_ev_p         = w_int ? (cnt_q == '0) : w_sum[ACC_W];
    w_ev_n         = w_int ? (cnt_q == (w_div >> 1)) :
                             (!acc_q[ACC_W-1] && w_sum[ACC_W-1]);
  end

  always_comb begin
    cur_d      = cur_q;
    pend_d     = w_pend_eff;
    pend_vld_d = w_pend_vld_eff;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    pcen_n_d   = 1'b1;
    ncen_n_d   = 1'b1;
    if (i_resync) begin
      cnt_d = '0;
      acc_d = '0;
      if (w_pend_vld_eff) begin
        cur_d      = cen_norm(w_pend_eff);
        pend_vld_d = 1'b0;
      end
    end else if (!i_halt) begin
      pcen_n_d = ~w_ev_p;
      ncen_n_d = ~w_ev_n;
      if (w_int) begin
        cnt_d = (cnt_q >= w_div - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
        acc_d = '0;
      end else begin
        cnt_d = '0;
        acc_d = w_sum[ACC_W-1:0];
      end
      // The cycle of a P event counts as phase 0 of the new setting
      if (w_pend_vld_eff && (w_ev_p || w_idle)) begin
        cur_d      = cen_norm(w_pend_eff);
        pend_vld_d = 1'b0;
        cnt_d      = w_ev_p ? CNT_W'(1) : '0;
        acc_d      = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q      <= c_def_cfg;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      pcen_n_q   <= 1'b1;
      ncen_n_q   <= 1'b1;
    end else begin
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      pcen_n_q   <= pcen_n_d;
      ncen_n_q   <= ncen_n_d;
    end
  end

  assign o_pcen_n = pcen_n_q;
  assign o_ncen_n = ncen_n_q;

endmodule
`default_nettype wire

// File: rtl/bubsys_cen_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bubsys_cen_gen : NCH-channel active-low P/N clock-enable generator   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bubsys_cen_gen
  import bubsys_cen_pkg::*;
#(
  parameter int                    NCH     = CEN_NCH_DEF,
  parameter int                    CNT_W   = CEN_CNT_W,
  parameter int                    ACC_W   = CEN_ACC_W,
  parameter logic [NCH*CNT_W-1:0]  DEF_DIV = {CEN_DIV_6M, CEN_DIV_9M, CEN_DIV_18M}
) (
  input  wire logic   i_EMU_MCLK,
  input  wire logic   i_EMU_MRST,
  bubsys_cen_if.slave cen_if
);

  cen_cfg_t       w_wr_cfg;
  logic [NCH-1:0] w_wr_en;
  logic [NCH-1:0] w_pcen_n;
  logic [NCH-1:0] w_ncen_n;

  assign w_wr_cfg = '{mode:  cen_mode_e'(cen_if.i_CFG_DATA[ACC_W]),
                      value: cen_if.i_CFG_DATA[ACC_W-1:0]};

  // Channel indices at or above NCH match no decode term and are dropped
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign w_wr_en[c] = cen_if.i_CFG_WR && (cen_if.i_CFG_CH == CEN_CH_W'(c));

    bubsys_cen_chan #(
      .CNT_W   (CNT_W),
      .ACC_W   (ACC_W),
      .DEF_DIV (DEF_DIV[c*CNT_W +: CNT_W])
    ) u_chan (
      .clk      (i_EMU_MCLK),
      .rst      (i_EMU_MRST),
      .i_halt   (cen_if.i_HALT),
      .i_resync (cen_if.i_RESYNC),
      .i_wr_en  (w_wr_en[c]),
      .i_wr_cfg (w_wr_cfg),
      .o_pcen_n (w_pcen_n[c]),
      .o_ncen_n (w_ncen_n[c])
    );
  end

  assign cen_if.o_PCEN_n = w_pcen_n;
  assign cen_if.o_NCEN_n = w_ncen_n;

endmodule
`default_nettype wire

// File: tb/tb_bubsys_cen_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bubsys_cen_gen : directed-vector bench for bubsys_cen_gen         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bubsys_cen_gen;
  import bubsys_cen_pkg::*;

  localparam int NCH   = 3;
  localparam int CNT_W = 5;
  localparam int ACC_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  // Bit k of each word is set when that enable was low in cycle k of a run
  logic [31:0] p_low [NCH];
  logic [31:0] n_low [NCH];

  bubsys_cen_if #(.NCH(NCH), .ACC_W(ACC_W)) cen_if ();

  bubsys_cen_gen #(
    .NCH     (NCH),
    .CNT_W   (CNT_W),
    .ACC_W   (ACC_W),
    .DEF_DIV ({5'd6, 5'd4, 5'd2})
  ) dut (
    .i_EMU_MCLK (clk),
    .i_EMU_MRST (rst),
    .cen_if     (cen_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    cen_if.i_HALT     = 1'b0;
    cen_if.i_RESYNC   = 1'b0;
    cen_if.i_CFG_WR   = 1'b0;
    cen_if.i_CFG_CH   = '0;
    cen_if.i_CFG_DATA = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    step();
    step();
    chk("rst_pcen", 32'(cen_if.o_PCEN_n), 32'h7);
    chk("rst_ncen", 32'(cen_if.o_NCEN_n), 32'h7);
    rst = 1'b0;
  endtask

  task automatic run_seq(input int n, input logic [31:0] halt_m, input logic [31:0] rsy_m,
                         input int wr_cyc, input logic [2:0] wr_ch, input logic [ACC_W:0] wr_dat);
    for (int c = 0; c < NCH; c++) begin
      p_low[c] = '0;
      n_low[c] = '0;
    end
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < NCH; c++) begin
        p_low[c][k] = ~cen_if.o_PCEN_n[c];
        n_low[c][k] = ~cen_if.o_NCEN_n[c];
      end
      cen_if.i_HALT     = halt_m[k];
      cen_if.i_RESYNC   = rsy_m[k];
      cen_if.i_CFG_WR   = (k == wr_cyc);
      cen_if.i_CFG_CH   = wr_ch;
      cen_if.i_CFG_DATA = wr_dat;
      step();
    end
    clear_in();
  endtask

  initial begin
    clear_in();

    // Defaults; a write to channel 5 must not land anywhere
    do_reset();
    run_seq(32, '0, '0, 2, 3'd5, {1'b0, 16'd8});
    chk("def_ch0_p", p_low[0], 32'hAAAAAAAA);
    chk("def_ch0_n", n_low[0], 32'h55555554);
    chk("def_ch1_p", p_low[1], 32'h22222222);
    chk("def_ch1_n", n_low[1], 32'h88888888);
    chk("def_ch2_p", p_low[2], 32'h82082082);
    chk("def_ch2_n", n_low[2], 32'h10410410);

    // Halt during cycles 4..6
    do_reset();
    run_seq(32, 32'h70, '0, -1, 3'd0, '0);
    chk("halt_ch1_p", p_low[1], 32'h11111102);
    chk("halt_ch1_n", n_low[1], 32'h44444408);
    chk("halt_ch0_p", p_low[0], 32'h5555550A);
    chk("halt_ch0_n", n_low[0], 32'hAAAAAA14);

    // ch1 -> integer 8, applied at its next wrap
    do_reset();
    run_seq(32, '0, '0, 2, 3'd1, {1'b0, 16'd8});
    chk("div8_ch1_p", p_low[1], 32'h20202022);
    chk("div8_ch1_n", n_low[1], 32'h02020208);
    chk("div8_ch0_p", p_low[0], 32'hAAAAAAAA);

    // ch2 -> fractional quarter rate
    do_reset();
    run_seq(32, '0, '0, 2, 3'd2, {1'b1, 16'h4000});
    chk("frac_ch2_p", p_low[2], 32'h88888882);
    chk("frac_ch2_n", n_low[2], 32'h22222210);

    // ch2 -> idle, then integer 2 applied immediately from idle
    do_reset();
    run_seq(32, '0, '0, 2, 3'd2, {1'b1, 16'h0000});
    chk("idle_ch2_p", p_low[2], 32'h00000082);
    chk("idle_ch2_n", n_low[2], 32'h00000010);
    run_seq(32, '0, '0, 3, 3'd2, {1'b0, 16'd2});
    chk("wake_ch2_p", p_low[2], 32'hAAAAAAA0);
    chk("wake_ch2_n", n_low[2], 32'h55555540);

    // Resync together with halt and a ch0 = 4 write at cycle 5
    do_reset();
    run_seq(32, 32'h20, 32'h20, 5, 3'd0, {1'b0, 16'd4});
    chk("rsy_ch0_p", p_low[0], 32'h888888AA);
    chk("rsy_ch0_n", n_low[0], 32'h22222214);
    chk("rsy_ch1_p", p_low[1], 32'h888888A2);
    chk("rsy_ch1_n", n_low[1], 32'h22222208);
    chk("rsy_ch2_p", p_low[2], 32'h82082082);
    chk("rsy_ch2_n", n_low[2], 32'h10410410);

    // Reset with ch1 config pending: defaults return
    do_reset();
    run_seq(3, '0, '0, 2, 3'd1, {1'b0, 16'd8});
    do_reset();
    run_seq(32, '0, '0, -1, 3'd0, '0);
    chk("mrst_ch1_p", p_low[1], 32'h22222222);
    chk("mrst_ch1_n", n_low[1], 32'h88888888);

    // Divider 0 clamps to 2
    do_reset();
    run_seq(32, '0, '0, 2, 3'd1, {1'b0, 16'd0});
    chk("clamp_ch1_p", p_low[1], 32'hAAAAAAA2);
    chk("clamp_ch1_n", n_low[1], 32'h55555548);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
